exc_ctrl: RTL

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : Precise-exception / interrupt sequencer feeding CP0 and fetch.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter int         IRQ_SYNC_STAGES = 2,
    parameter logic [4:0] CODE_INT        = 5'd0,
    parameter logic [4:0] CODE_SYS        = 5'd8,
    parameter logic [4:0] CODE_BP         = 5'd9,
    parameter logic [4:0] CODE_RI         = 5'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        is_syscall,
    input  logic        is_break,
    input  logic        is_ri,
    input  logic        is_eret,
    input  logic        irq,
    input  logic [31:0] handler_pc,
    input  logic [31:0] epc,
    output logic        exl_set,
    output logic        exl_clear,
    output logic [31:0] save_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [4:0]  cause,
    output logic        in_handler,
    output logic        double_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] save_pc_q, save_pc_d;
    logic [4:0]  cause_q, cause_d;
    logic        dfault_q, dfault_d;
    logic        irq_pend_q, irq_pend_d;
    logic        irq_prev_q;
    logic        take_irq;
    logic [IRQ_SYNC_STAGES-1:0] sync_q;

    // Synchronizer chain; the MSB is the metastability-safe copy of irq.
    generate
        if (IRQ_SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '0;
                else     sync_q <= irq;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '0;
                else     sync_q <= {sync_q[IRQ_SYNC_STAGES-2:0], irq};
            end
        end
    endgenerate

    wire accept   = instr_valid & ~stall;
    wire irq_rise = sync_q[IRQ_SYNC_STAGES-1] & ~irq_prev_q;
    wire sync_exc = is_ri | is_syscall | is_break;

    always_comb begin
        state_d   = state_q;
        save_pc_d = save_pc_q;
        cause_d   = cause_q;
        dfault_d  = dfault_q;
        take_irq  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (irq_pend_q || sync_exc || is_eret)) begin
                    state_d   = TAKE;
                    save_pc_d = pc;
                    if (irq_pend_q) begin
                        cause_d  = CODE_INT;
                        take_irq = 1'b1;
                    end else if (is_ri)      cause_d = CODE_RI;
                    else if (is_syscall)     cause_d = CODE_SYS;
                    else if (is_break)       cause_d = CODE_BP;
                    else                     cause_d = CODE_RI; // eret outside a handler is illegal
                end
            end
            TAKE:    state_d = HANDLER;
            HANDLER: begin
                if (accept && sync_exc)     dfault_d = 1'b1;
                else if (accept && is_eret) state_d  = RET;
            end
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new edge arriving in the same cycle as the take must not be lost.
        irq_pend_d = (irq_pend_q & ~take_irq) | irq_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            save_pc_q  <= '0;
            cause_q    <= '0;
            dfault_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            save_pc_q  <= save_pc_d;
            cause_q    <= cause_d;
            dfault_q   <= dfault_d;
            irq_pend_q <= irq_pend_d;
            irq_prev_q <= sync_q[IRQ_SYNC_STAGES-1];
        end
    end

    // Moore decode; rst forces the control pulses low even mid-TAKE/RET.
    assign exl_set      = ~rst & (state_q == TAKE);
    assign exl_clear    = ~rst & (state_q == RET);
    assign redirect     = exl_set | exl_clear;
    assign flush        = exl_set | exl_clear;
    assign in_handler   = ~rst & ((state_q == HANDLER) || (state_q == RET));
    assign redirect_pc  = exl_set ? handler_pc : (exl_clear ? epc : 32'd0);
    assign save_pc      = save_pc_q;
    assign cause        = cause_q;
    assign double_fault = dfault_q;

endmodule
`default_nettype wire
